// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers for the E-stage.
// Results come from a combinational datapath on the captured operands; a down-counter paces completion.
module md_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbg_state
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int W2      = 2 * WIDTH;

    // Handshake: start is sampled at each rising edge against the pre-edge state;
    // it is accepted only in IDLE, and done pulses for one cycle when HI/LO update.
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]       opc_q, opc_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;

    logic [W2-1:0]    prod_s, prod_u, result;
    logic [WIDTH-1:0] quo_s, rem_s, quo_u, rem_u;
    logic [WIDTH-1:0] b_div_s, b_div_u;
    logic             b_zero, div_ovf;

    assign b_zero  = (b_q == '0);
    assign div_ovf = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
    // Special cases divide by 1 so the datapath never sees divide-by-zero or signed overflow.
    assign b_div_s = (b_zero || div_ovf) ? WIDTH'(1) : b_q;
    assign b_div_u = b_zero ? WIDTH'(1) : b_q;

    assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    assign quo_s  = $signed(a_q) / $signed(b_div_s);
    assign rem_s  = $signed(a_q) % $signed(b_div_s);
    assign quo_u  = a_q / b_div_u;
    assign rem_u  = a_q % b_div_u;

    always_comb begin
        result = '0;
        unique case (opc_q)
            2'd0: result = prod_s;
            2'd1: result = prod_u;
            2'd2: begin
                if (b_zero)       result = {a_q, {WIDTH{1'b1}}};
                else if (div_ovf) result = {{WIDTH{1'b0}}, a_q};
                else              result = {rem_s, quo_s};
            end
            default: begin
                if (b_zero) result = {a_q, {WIDTH{1'b1}}};
                else        result = {rem_u, quo_u};
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        opc_d   = opc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    unique case (op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            a_d     = a;
                            b_d     = b;
                            opc_d   = op[1:0];
                            cnt_d   = op[1] ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);
                            state_d = S_RUN;
                        end
                        3'd4:    hi_d = a;
                        3'd5:    lo_d = a;
                        default: ;
                    endcase
                end
            end
            default: begin
                // Cancel wins over a completion falling on the same edge.
                if (cancel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = result;
                    done_d       = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            opc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            opc_q   <= opc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed-vector bench for md_unit: a 32-bit default instance and a 16-bit fast instance.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start, cancel;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        busy, done, dbg;

    logic        s_start, s_cancel;
    logic [2:0]  s_op;
    logic [15:0] s_a, s_b, s_hi, s_lo;
    logic        s_busy, s_done, s_dbg;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    md_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state(dbg)
    );

    md_unit #(.WIDTH(16), .MULT_LAT(1), .DIV_LAT(3)) dut16 (
        .clk(clk), .reset(reset), .start(s_start), .op(s_op), .a(s_a), .b(s_b),
        .cancel(s_cancel), .busy(s_busy), .done(s_done), .hi(s_hi), .lo(s_lo), .dbg_state(s_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver: issue one op, then watch busy/done over a fixed window
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int nbusy, output int ndone);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0; ndone = 0;
        for (int i = 0; i < 14; i++) begin
            if (busy) nbusy++;
            if (done) ndone++;
            @(negedge clk);
        end
    endtask

    task automatic do_op16(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                           output int nbusy, output int ndone);
        @(negedge clk);
        s_start = 1'b1; s_op = o; s_a = x; s_b = y;
        @(negedge clk);
        s_start = 1'b0;
        nbusy = 0; ndone = 0;
        for (int i = 0; i < 5; i++) begin
            if (s_busy) nbusy++;
            if (s_done) ndone++;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] model16(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        longint sx, sy, ux, uy, p, q, r;
        sx = $signed(x);
        sy = $signed(y);
        ux = longint'(x);
        uy = longint'(y);
        p = 0; q = 0; r = 0;
        case (o)
            3'd0: p = sx * sy;
            3'd1: p = ux * uy;
            3'd2: begin
                if (y == 16'h0) return {x, 16'hFFFF};
                q = sx / sy; r = sx % sy;
                p = {r[15:0], q[15:0]};
            end
            3'd3: begin
                if (y == 16'h0) return {x, 16'hFFFF};
                q = ux / uy; r = ux % uy;
                p = {r[15:0], q[15:0]};
            end
            default: p = 0;
        endcase
        return p[31:0];
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int nb, nd, ndone_total;
        logic [2:0]  ro;
        logic [15:0] rx, ry;
        logic [31:0] e;

        vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd3, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 10};
        vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 10};
        vecs[5]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
        vecs[6]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       10};
        vecs[7]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
        vecs[8]  = '{3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 10};
        vecs[9]  = '{3'd1, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        5};
        vecs[10] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        5};
        vecs[11] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'd1,        32'h7FFFFFFC, 10};
        vecs[12] = '{3'd4, 32'hDEAD,     32'd0,        32'hDEAD,     32'h7FFFFFFC, 0};
        vecs[13] = '{3'd5, 32'hBEEF,     32'd0,        32'hDEAD,     32'hBEEF,     0};
        vecs[14] = '{3'd6, 32'h123,      32'd5,        32'hDEAD,     32'hBEEF,     0};
        vecs[15] = '{3'd7, 32'h456,      32'd5,        32'hDEAD,     32'hBEEF,     0};
        vecs[16] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        10};

        reset = 1'b0; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
        s_start = 1'b0; s_cancel = 1'b0; s_op = '0; s_a = '0; s_b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset16_hilo", {s_busy, s_done, s_hi, s_lo}, 0);
        reset = 1'b1;

        // table-driven vectors on the 32-bit instance
        for (int i = 0; i < 17; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, nb, nd);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
            check($sformatf("vec%0d_busy_cycles", i), nb, vecs[i].lat);
            check($sformatf("vec%0d_done_pulses", i), nd, (vecs[i].lat > 0) ? 1 : 0);
        end

        // reset on the 2nd cycle of RUN
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'hFFFFFFFE; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rst_run_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        check("rst_run_busy", busy, 0);
        check("rst_run_done", done, 0);
        check("rst_run_hi", hi, 0);
        check("rst_run_lo", lo, 0);
        @(negedge clk);
        reset = 1'b1;
        do_op(3'd0, 32'hFFFFFFFE, 32'd3, nb, nd);
        check("post_rst_hi", hi, 32'hFFFFFFFF);
        check("post_rst_lo", lo, 32'hFFFFFFFA);
        check("post_rst_busy_cycles", nb, 5);
        check("post_rst_done_pulses", nd, 1);

        // cancel on the completion cycle, with an ignored MTHI during RUN
        do_op(3'd4, 32'h1234, 32'd0, nb, nd);
        do_op(3'd5, 32'h5678, 32'd0, nb, nd);
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'hAAAA;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("cancel_busy_last_cycle", busy, 1);
        check("cancel_hi_during_run", hi, 32'h1234);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", busy, 0);
        check("cancel_done", done, 0);
        check("cancel_hi", hi, 32'h1234);
        check("cancel_lo", lo, 32'h5678);
        @(negedge clk);
        check("cancel_done_late", done, 0);
        check("cancel_hilo_late", {hi, lo}, {32'h1234, 32'h5678});

        // cancel in IDLE does not block a start
        @(negedge clk);
        cancel = 1'b1; start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd3;
        @(negedge clk);
        cancel = 1'b0; start = 1'b0;
        check("idle_cancel_busy", busy, 1);
        repeat (5) @(negedge clk);
        check("idle_cancel_done", done, 1);
        check("idle_cancel_result", {hi, lo}, {32'd0, 32'd6});

        // back-to-back: start held high, acceptances every 6 edges
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd4;
        ndone_total = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (done) ndone_total++;
            check($sformatf("b2b_busy_%0d", i), busy, ((i % 6) != 5) ? 1 : 0);
            check($sformatf("b2b_done_%0d", i), done, ((i % 6) == 5) ? 1 : 0);
        end
        start = 1'b0;
        check("b2b_done_total", ndone_total, 3);
        check("b2b_result", {hi, lo}, {32'd0, 32'd20});
        @(negedge clk);
        check("b2b_idle_after", {busy, done}, 2'b00);

        // 16-bit instance: directed rows, then random operands against the model
        do_op16(3'd0, 16'hFFFE, 16'd3, nb, nd);
        check("w16_mult_hilo", {s_hi, s_lo}, 32'hFFFFFFFA);
        check("w16_mult_busy_cycles", nb, 1);
        check("w16_mult_done", nd, 1);
        do_op16(3'd2, 16'hFFF9, 16'd2, nb, nd);
        check("w16_div_hilo", {s_hi, s_lo}, 32'hFFFFFFFD);
        check("w16_div_busy_cycles", nb, 3);
        do_op16(3'd2, 16'h8000, 16'hFFFF, nb, nd);
        check("w16_div_ovf", {s_hi, s_lo}, 32'h00008000);
        do_op16(3'd3, 16'd9, 16'd0, nb, nd);
        check("w16_divu_zero", {s_hi, s_lo}, 32'h0009FFFF);

        for (int i = 0; i < 1000; i++) begin
            ro = 3'($urandom_range(0, 3));
            rx = 16'($urandom);
            ry = 16'($urandom);
            case ($urandom_range(0, 9))
                0: ry = 16'h0;
                1: begin rx = 16'h8000; ry = 16'hFFFF; end
                default: ;
            endcase
            exp_q.push_back(model16(ro, rx, ry));
            do_op16(ro, rx, ry, nb, nd);
            e = exp_q.pop_front();
            check($sformatf("rnd%0d_op%0d_a%h_b%h", i, ro, rx, ry), {s_hi, s_lo}, e);
            check($sformatf("rnd%0d_busy_cycles", i), nb, (ro < 3'd2) ? 1 : 3);
            check($sformatf("rnd%0d_done", i), nd, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
